// File: rtl/wc_pkg.sv
// rtl/wc_pkg.sv - shared sample/tile types and window helpers for the wc stage
package wc_pkg;

    localparam int SAMPLE_W    = 10;
    localparam int TAPS_IN     = 5;
    localparam int TILE_STRIDE = 2;

    typedef logic signed [SAMPLE_W-1:0]         sample_t;
    // Element [TAPS_IN-1] is the oldest sample and lands in the MSBs of the tile.
    typedef logic [TAPS_IN-1:0][SAMPLE_W-1:0]   tile_t;

    typedef enum logic {
        FILL   = 1'b0,
        STEADY = 1'b1
    } feed_state_e;

    function automatic tile_t shift_in(input tile_t w, input sample_t s);
        return {w[TAPS_IN-2:0], s};
    endfunction

    // Pushes n zero samples in at the newest end.
    function automatic tile_t zero_pad(input tile_t t, input logic [2:0] n);
        return t << (32'(n) * SAMPLE_W);
    endfunction

endpackage

// File: rtl/wc_win_shift.sv
// rtl/wc_win_shift.sv - 5-entry sample window with load-enable and synchronous clear
module wc_win_shift
    import wc_pkg::*;
(
    input  logic    clk,
    input  logic    clr_i,
    input  logic    en_i,
    input  sample_t sample_i,
    output tile_t   win_o
);

    tile_t win_q;

    always_ff @(posedge clk) begin
        if (clr_i) begin
            win_q <= '0;
        end else if (en_i) begin
            win_q <= shift_in(win_q, sample_i);
        end
    end

    assign win_o = win_q;

endmodule

// File: rtl/wc_tile_feeder.sv
// rtl/wc_tile_feeder.sv - overlapping 5-sample tile feeder; WC_FEED_ZPAD_EN zero-pads partial tails instead of dropping them
module wc_tile_feeder
    import wc_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic [SAMPLE_W-1:0]         in_data,
    input  logic                        in_last,
    output logic                        in_ready,
    output logic [TAPS_IN*SAMPLE_W-1:0] D,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_last,
    output logic                        drop
);

    feed_state_e state_q, state_d;
    logic [2:0]  fill_cnt_q, fill_cnt_d;
    logic        phase_q, phase_d;
    tile_t       d_q, d_d;
    logic        out_valid_q, out_valid_d;
    logic        out_last_q, out_last_d;
    logic        drop_q, drop_d;

    tile_t       win, win_shift;
    logic        accept, complete, win_clr;

    assign in_ready  = ~out_valid_q | out_ready;
    assign accept    = in_valid & in_ready;
    assign win_shift = shift_in(win, sample_t'(in_data));
    assign complete  = (state_q == FILL) ? (fill_cnt_q == 3'(TAPS_IN-1))
                                         : (phase_q == 1'(TILE_STRIDE-1));

`ifdef WC_FEED_ZPAD_EN
    logic [2:0] pad_cnt;
    assign pad_cnt = (state_q == FILL) ? 3'(TAPS_IN-1) - fill_cnt_q : 3'(TILE_STRIDE-1);
`endif

    wc_win_shift u_win (
        .clk      (clk),
        .clr_i    (rst | win_clr),
        .en_i     (accept),
        .sample_i (sample_t'(in_data)),
        .win_o    (win)
    );

    always_comb begin
        state_d     = state_q;
        fill_cnt_d  = fill_cnt_q;
        phase_d     = phase_q;
        d_d         = d_q;
        out_valid_d = out_valid_q & ~out_ready;
        out_last_d  = out_last_q & ~out_ready;
        drop_d      = 1'b0;
        win_clr     = 1'b0;
        if (accept) begin
            if (complete) begin
                // A new tile overwrites any tile consumed this same cycle.
                d_d         = win_shift;
                out_valid_d = 1'b1;
                out_last_d  = in_last;
                state_d     = STEADY;
                phase_d     = 1'b0;
                fill_cnt_d  = '0;
            end else if (state_q == FILL) begin
                fill_cnt_d = fill_cnt_q + 3'd1;
            end else begin
                phase_d = ~phase_q;
            end
            if (in_last) begin
                state_d    = FILL;
                fill_cnt_d = '0;
                phase_d    = 1'b0;
                win_clr    = 1'b1;
                if (!complete) begin
`ifdef WC_FEED_ZPAD_EN
                    d_d         = zero_pad(win_shift, pad_cnt);
                    out_valid_d = 1'b1;
                    out_last_d  = 1'b1;
`else
                    drop_d      = 1'b1;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL;
            fill_cnt_q  <= '0;
            phase_q     <= 1'b0;
            d_q         <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_cnt_q  <= fill_cnt_d;
            phase_q     <= phase_d;
            d_q         <= d_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            drop_q      <= drop_d;
        end
    end

    assign D         = d_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign drop      = drop_q;

endmodule

// File: tb/tb_wc_tile_feeder.sv
// tb/tb_wc_tile_feeder.sv - self-checking bench for wc_tile_feeder against a frame-level tiling model
module tb_wc_tile_feeder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [9:0]  in_data = '0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic [49:0] D;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_last;
    logic        drop;

    int n_checks = 0;
    int n_fail   = 0;
    int rdy_mode = 1;

    logic [9:0]  frame_q[$];
    logic [49:0] exp_tiles[$];
    bit          exp_last[$];
    int          exp_drops = 0;
    logic [49:0] got_tiles[$];
    bit          got_last[$];
    int          got_drops = 0;

    wc_tile_feeder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .D         (D),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .drop      (drop)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                got_tiles.push_back(D);
                got_last.push_back(out_last);
            end
            if (drop) got_drops++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [49:0] mk5(input int a, input int b, input int c, input int d, input int e);
        return {a[9:0], b[9:0], c[9:0], d[9:0], e[9:0]};
    endfunction

    // Expected tiles for one frame: windows start at 0,2,4,... and a leftover tail is padded or dropped.
    task automatic model_frame(input bit ended);
        int n;
        int k;
        logic [49:0] t;
        n = frame_q.size();
        for (int s = 0; s + 5 <= n; s += 2) begin
            t = '0;
            for (int j = 0; j < 5; j++) t = {t[39:0], frame_q[s+j]};
            exp_tiles.push_back(t);
            exp_last.push_back(ended && (s + 5 == n));
        end
        if (ended) begin
            k = (n < 5) ? n : (((n - 5) % 2 == 1) ? 4 : 0);
            if (k > 0) begin
`ifdef WC_FEED_ZPAD_EN
                t = '0;
                for (int j = 0; j < 5; j++) t = {t[39:0], (j < k) ? frame_q[n-k+j] : 10'd0};
                exp_tiles.push_back(t);
                exp_last.push_back(1'b1);
`else
                exp_drops++;
`endif
            end
        end
        frame_q.delete();
    endtask

    task automatic clear_sb();
        exp_tiles.delete(); exp_last.delete(); exp_drops = 0;
        got_tiles.delete(); got_last.delete(); got_drops = 0;
        frame_q.delete();
    endtask

    task automatic push(input logic [9:0] s, input bit l);
        int guard;
        guard = 0;
        in_valid = 1'b1; in_data = s; in_last = l;
        do begin
            @(negedge clk);
            guard++;
        end while (!in_ready && guard < 200);
        if (!in_ready) begin
            n_checks++; n_fail++;
            $display("FAIL push_timeout: in_ready=%b required 1", in_ready);
        end else begin
            frame_q.push_back(s);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic drain();
        rdy_mode = 1;
        repeat (6) @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
        n_checks++; if (out_last !== 1'b0)  begin n_fail++; $display("FAIL reset_out_last: got %b required 0", out_last); end
        n_checks++; if (drop !== 1'b0)      begin n_fail++; $display("FAIL reset_drop: got %b required 0", drop); end
        n_checks++; if (D !== 50'd0)        begin n_fail++; $display("FAIL reset_D: got %h required 0", D); end
        n_checks++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL post_reset_in_ready: got %b required 1", in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        int fa[7] = '{2, -10, 3, 4, -13, 5, 6};
        int fb[5] = '{-19, -6, 3, -9, -12};
        clear_sb();
        rdy_mode = 1;
        for (int i = 0; i < 5; i++) push(10'(fa[i]), 1'b0);
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL first_tile_valid: got %b required 1", out_valid); end
        n_checks++; if (D !== 50'b0000000010_1111110110_0000000011_0000000100_1111110011)
            begin n_fail++; $display("FAIL first_tile_D: got %h required %h", D, mk5(2, -10, 3, 4, -13)); end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL first_tile_one_cycle: got %b required 0", out_valid); end
        @(posedge clk); #1;
        push(10'(fa[5]), 1'b0);
        push(10'(fa[6]), 1'b1);
        @(negedge clk);
        n_checks++; if ({out_valid, out_last, D} !== {2'b11, mk5(3, 4, -13, 5, 6)})
            begin n_fail++; $display("FAIL overlap_tile: got v=%b l=%b D=%h required v=1 l=1 D=%h", out_valid, out_last, D, mk5(3, 4, -13, 5, 6)); end
        @(posedge clk); #1;
        model_frame(1'b1);
        for (int i = 0; i < 5; i++) push(10'(fb[i]), i == 4);
        @(negedge clk);
        n_checks++; if ({out_valid, out_last, D} !== {2'b11, mk5(-19, -6, 3, -9, -12)})
            begin n_fail++; $display("FAIL new_frame_tile: got v=%b l=%b D=%h required v=1 l=1 D=%h", out_valid, out_last, D, mk5(-19, -6, 3, -9, -12)); end
        @(posedge clk); #1;
        model_frame(1'b1);
        drain();
        n_checks++; if (got_tiles.size() != exp_tiles.size()) begin n_fail++; $display("FAIL directed_count: got %0d required %0d", got_tiles.size(), exp_tiles.size()); end
        for (int i = 0; i < got_tiles.size() && i < exp_tiles.size(); i++) begin
            n_checks++;
            if ({got_last[i], got_tiles[i]} !== {exp_last[i], exp_tiles[i]}) begin
                n_fail++; $display("FAIL directed_tile%0d: got l=%b %h required l=%b %h", i, got_last[i], got_tiles[i], exp_last[i], exp_tiles[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        clear_sb();
        rdy_mode = 0;
        @(posedge clk); #1;
        for (int i = 1; i <= 5; i++) push(10'(i), 1'b0);
        in_valid = 1'b1; in_data = 10'd6; in_last = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_checks++;
            if ({out_valid, in_ready, D} !== {2'b10, mk5(1, 2, 3, 4, 5)}) begin
                n_fail++; $display("FAIL hold_cycle%0d: got v=%b in_ready=%b D=%h required v=1 in_ready=0 D=%h", c, out_valid, in_ready, D, mk5(1, 2, 3, 4, 5));
            end
        end
        rdy_mode = 1;
        push(10'd6, 1'b0);
        push(10'd7, 1'b1);
        model_frame(1'b1);
        drain();
        n_checks++; if (got_tiles.size() != exp_tiles.size()) begin n_fail++; $display("FAIL bp_count: got %0d required %0d", got_tiles.size(), exp_tiles.size()); end
        for (int i = 0; i < got_tiles.size() && i < exp_tiles.size(); i++) begin
            n_checks++;
            if ({got_last[i], got_tiles[i]} !== {exp_last[i], exp_tiles[i]}) begin
                n_fail++; $display("FAIL bp_tile%0d: got l=%b %h required l=%b %h", i, got_last[i], got_tiles[i], exp_last[i], exp_tiles[i]);
            end
        end
    endtask

    task automatic test_tail();
        clear_sb();
        rdy_mode = 1;
        for (int i = 1; i <= 6; i++) push(10'(i), i == 6);
        model_frame(1'b1);
        for (int i = 7; i <= 9; i++) push(10'(i), i == 9);
        model_frame(1'b1);
        drain();
`ifdef WC_FEED_ZPAD_EN
        n_checks++; if (got_tiles.size() < 2 || {got_last[1], got_tiles[1]} !== {1'b1, mk5(3, 4, 5, 6, 0)})
            begin n_fail++; $display("FAIL steady_pad_tile: got %0d tiles, required second tile %h last=1", got_tiles.size(), mk5(3, 4, 5, 6, 0)); end
`else
        n_checks++; if (got_drops != 2) begin n_fail++; $display("FAIL drop_pulses: got %0d required 2", got_drops); end
`endif
        n_checks++; if (got_tiles.size() != exp_tiles.size()) begin n_fail++; $display("FAIL tail_count: got %0d required %0d", got_tiles.size(), exp_tiles.size()); end
        for (int i = 0; i < got_tiles.size() && i < exp_tiles.size(); i++) begin
            n_checks++;
            if ({got_last[i], got_tiles[i]} !== {exp_last[i], exp_tiles[i]}) begin
                n_fail++; $display("FAIL tail_tile%0d: got l=%b %h required l=%b %h", i, got_last[i], got_tiles[i], exp_last[i], exp_tiles[i]);
            end
        end
        n_checks++; if (got_drops != exp_drops) begin n_fail++; $display("FAIL tail_drops: got %0d required %0d", got_drops, exp_drops); end
    endtask

    task automatic test_reset_mid();
        clear_sb();
        rdy_mode = 1;
        for (int i = 0; i < 3; i++) push(10'(100 + i), 1'b0);
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        n_checks++; if ({out_valid, out_last, drop, D} !== 53'd0)
            begin n_fail++; $display("FAIL reset_mid_frame: got v=%b l=%b drop=%b D=%h required all 0", out_valid, out_last, drop, D); end
        @(posedge clk); #1;
        rdy_mode = 0;
        for (int i = 0; i < 5; i++) push(10'(200 + i), 1'b0);
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        n_checks++; if ({out_valid, out_last, drop, D} !== 53'd0)
            begin n_fail++; $display("FAIL reset_mid_hold: got v=%b l=%b drop=%b D=%h required all 0", out_valid, out_last, drop, D); end
        @(posedge clk); #1;
        clear_sb();
        rdy_mode = 1;
        for (int i = 0; i < 5; i++) push(10'(300 + i), i == 4);
        drain();
        n_checks++; if (got_tiles.size() != 1 || {got_last[0], got_tiles[0]} !== {1'b1, mk5(300, 301, 302, 303, 304)})
            begin n_fail++; $display("FAIL post_reset_frame: got %0d tiles, required one tile %h last=1", got_tiles.size(), mk5(300, 301, 302, 303, 304)); end
    endtask

    task automatic test_random();
        int len;
        clear_sb();
        rdy_mode = 2;
        for (int f = 0; f < 12; f++) begin
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) begin
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                push(10'($urandom), i == len - 1);
            end
            model_frame(1'b1);
        end
        drain();
        n_checks++; if (got_tiles.size() != exp_tiles.size()) begin n_fail++; $display("FAIL rand_count: got %0d required %0d", got_tiles.size(), exp_tiles.size()); end
        for (int i = 0; i < got_tiles.size() && i < exp_tiles.size(); i++) begin
            n_checks++;
            if ({got_last[i], got_tiles[i]} !== {exp_last[i], exp_tiles[i]}) begin
                n_fail++; $display("FAIL rand_tile%0d: got l=%b %h required l=%b %h", i, got_last[i], got_tiles[i], exp_last[i], exp_tiles[i]);
            end
        end
        n_checks++; if (got_drops != exp_drops) begin n_fail++; $display("FAIL rand_drops: got %0d required %0d", got_drops, exp_drops); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_tail();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
